// File: rtl/radix2_pair_feeder.sv
// radix2_pair_feeder
// Streaming front-end for a parallel-input radix-2 butterfly. The first half
// of every N-point frame is buffered; each second-half sample x[k+N/2] is
// presented together with its buffered partner x[k], the twiddle index k,
// a one-cycle enable and the frame's modify select. Samples pass bit-exact.
// The FILL/PAIR state is simply the MSB of the index counter, so no separate
// state register exists.

module radix2_pair_feeder #(
    parameter int bit_width = 16,
    parameter int N         = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  sync,
    input  logic                  modify_sel,
    input  logic [bit_width-1:0]  Re_in,
    input  logic [bit_width-1:0]  Im_in,
    output logic [bit_width-1:0]  Re_i1,
    output logic [bit_width-1:0]  Im_i1,
    output logic [bit_width-1:0]  Re_i2,
    output logic [bit_width-1:0]  Im_i2,
    output logic [ADDR_W-2:0]     tw_addr,
    output logic                  en,
    output logic                  en_modify,
    output logic                  pair_last,
    output logic                  sync_err
);

    localparam int HALF = N / 2;

    // Frame index; MSB set means the PAIR half of the frame
    logic [ADDR_W-1:0]    r_idx;

    // First-half sample storage (no reset: contents are don't-care)
    logic [bit_width-1:0] r_buf_re [HALF];
    logic [bit_width-1:0] r_buf_im [HALF];

    // Registered outputs
    logic [bit_width-1:0] r_re_i1;
    logic [bit_width-1:0] r_im_i1;
    logic [bit_width-1:0] r_re_i2;
    logic [bit_width-1:0] r_im_i2;
    logic [ADDR_W-2:0]    r_tw_addr;
    logic                 r_en;
    logic                 r_en_modify;
    logic                 r_pair_last;
    logic                 r_sync_err;

    // Decoded per-cycle actions
    logic                 w_wr_en;
    logic [ADDR_W-2:0]    w_wr_addr;
    logic [ADDR_W-2:0]    w_rd_addr;
    logic                 w_pair_fire;
    logic                 w_load_mod;
    logic                 w_sync_err;
    logic                 w_is_last;
    logic [ADDR_W-1:0]    w_idx_nxt;

    // In PAIR the low bits of idx equal idx-N/2, i.e. the partner address k
    assign w_rd_addr = r_idx[ADDR_W-2:0];
    assign w_is_last = (r_idx == ADDR_W'(N - 1));

    // Decode what the current cycle does: fill, pair, resync or hold
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_addr   = {(ADDR_W-1){1'b0}};
        w_pair_fire = 1'b0;
        w_load_mod  = 1'b0;
        w_sync_err  = 1'b0;
        w_idx_nxt   = r_idx;
        if (in_valid) begin
            if (sync) begin
                // Forced index 0: any partial frame is abandoned
                w_wr_en    = 1'b1;
                w_wr_addr  = {(ADDR_W-1){1'b0}};
                w_load_mod = 1'b1;
                w_sync_err = (r_idx != {ADDR_W{1'b0}});
                w_idx_nxt  = ADDR_W'(1);
            end else if (!r_idx[ADDR_W-1]) begin
                w_wr_en    = 1'b1;
                w_wr_addr  = r_idx[ADDR_W-2:0];
                w_load_mod = (r_idx == {ADDR_W{1'b0}});
                w_idx_nxt  = r_idx + ADDR_W'(1);
            end else begin
                // Increment wraps N-1 -> 0 naturally since N = 2**ADDR_W
                w_pair_fire = 1'b1;
                w_idx_nxt   = r_idx + ADDR_W'(1);
            end
        end else begin
            w_idx_nxt = r_idx;
        end
    end

    // Index counter and frame-level control flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= {ADDR_W{1'b0}};
            r_en_modify <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_idx      <= w_idx_nxt;
            r_sync_err <= w_sync_err;
            if (w_load_mod) begin
                r_en_modify <= modify_sel;
            end else begin
                r_en_modify <= r_en_modify;
            end
        end
    end

    // Pair output registers; data and tw_addr hold when no pair fires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_re_i1     <= {bit_width{1'b0}};
            r_im_i1     <= {bit_width{1'b0}};
            r_re_i2     <= {bit_width{1'b0}};
            r_im_i2     <= {bit_width{1'b0}};
            r_tw_addr   <= {(ADDR_W-1){1'b0}};
            r_en        <= 1'b0;
            r_pair_last <= 1'b0;
        end else begin
            r_en        <= w_pair_fire;
            r_pair_last <= w_pair_fire & w_is_last;
            if (w_pair_fire) begin
                r_re_i1   <= r_buf_re[w_rd_addr];
                r_im_i1   <= r_buf_im[w_rd_addr];
                r_re_i2   <= Re_in;
                r_im_i2   <= Im_in;
                r_tw_addr <= w_rd_addr;
            end else begin
                r_re_i1   <= r_re_i1;
                r_im_i1   <= r_im_i1;
                r_re_i2   <= r_re_i2;
                r_im_i2   <= r_im_i2;
                r_tw_addr <= r_tw_addr;
            end
        end
    end

    // First-half buffer write; written only in FILL, read only in PAIR
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf_re[w_wr_addr] <= Re_in;
            r_buf_im[w_wr_addr] <= Im_in;
        end
    end

    assign Re_i1     = r_re_i1;
    assign Im_i1     = r_im_i1;
    assign Re_i2     = r_re_i2;
    assign Im_i2     = r_im_i2;
    assign tw_addr   = r_tw_addr;
    assign en        = r_en;
    assign en_modify = r_en_modify;
    assign pair_last = r_pair_last;
    assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_radix2_pair_feeder.sv
// Self-checking bench for radix2_pair_feeder: directed frames plus a random
// stream, compared every cycle against a frame-position reference model.

module tb_radix2_pair_feeder;

    localparam int BW   = 16;
    localparam int N    = 16;
    localparam int AW   = 4;
    localparam int HALF = N / 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          sync;
    logic          modify_sel;
    logic [BW-1:0] Re_in;
    logic [BW-1:0] Im_in;
    logic [BW-1:0] Re_i1;
    logic [BW-1:0] Im_i1;
    logic [BW-1:0] Re_i2;
    logic [BW-1:0] Im_i2;
    logic [AW-2:0] tw_addr;
    logic          en;
    logic          en_modify;
    logic          pair_last;
    logic          sync_err;

    radix2_pair_feeder #(.bit_width(BW), .N(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sync(sync),
        .modify_sel(modify_sel), .Re_in(Re_in), .Im_in(Im_in),
        .Re_i1(Re_i1), .Im_i1(Im_i1), .Re_i2(Re_i2), .Im_i2(Im_i2),
        .tw_addr(tw_addr), .en(en), .en_modify(en_modify),
        .pair_last(pair_last), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int en_count = 0;
    int err_count = 0;

    // Reference model: position within frame plus stored first half
    int            m_pos;
    logic [BW-1:0] m_re [HALF];
    logic [BW-1:0] m_im [HALF];
    logic [BW-1:0] e_re1, e_im1, e_re2, e_im2;
    int            e_tw;
    logic          e_en, e_last, e_err, e_mod;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("Re_i1", 32'(Re_i1), 32'(e_re1));
        check_val("Im_i1", 32'(Im_i1), 32'(e_im1));
        check_val("Re_i2", 32'(Re_i2), 32'(e_re2));
        check_val("Im_i2", 32'(Im_i2), 32'(e_im2));
        check_val("tw_addr", 32'(tw_addr), 32'(e_tw));
        check_val("en", 32'(en), 32'(e_en));
        check_val("pair_last", 32'(pair_last), 32'(e_last));
        check_val("sync_err", 32'(sync_err), 32'(e_err));
        check_val("en_modify", 32'(en_modify), 32'(e_mod));
    endtask

    task automatic model_reset();
        m_pos = 0;
        e_re1 = '0; e_im1 = '0; e_re2 = '0; e_im2 = '0;
        e_tw = 0; e_en = 1'b0; e_last = 1'b0; e_err = 1'b0; e_mod = 1'b0;
    endtask

    // Apply one input cycle, advance the model, compare after the edge
    task automatic step(input logic v, input logic s, input logic m,
                        input logic [BW-1:0] re, input logic [BW-1:0] im);
        in_valid = v; sync = s; modify_sel = m; Re_in = re; Im_in = im;
        @(posedge clk);
        #1;
        e_en = 1'b0; e_last = 1'b0; e_err = 1'b0;
        if (v) begin
            if (s) begin
                e_err = (m_pos != 0);
                m_pos = 0;
            end
            if (m_pos == 0) e_mod = m;
            if (m_pos < HALF) begin
                m_re[m_pos] = re;
                m_im[m_pos] = im;
            end else begin
                e_re1 = m_re[m_pos - HALF];
                e_im1 = m_im[m_pos - HALF];
                e_re2 = re;
                e_im2 = im;
                e_tw  = m_pos - HALF;
                e_en  = 1'b1;
                e_last = (m_pos == N - 1);
            end
            m_pos = (m_pos + 1) % N;
        end
        check_outputs();
        if (en === 1'b1) en_count++;
        if (sync_err === 1'b1) err_count++;
        in_valid = 1'b0; sync = 1'b0;
    endtask

    logic [BW-1:0] neg_k;
    int            base;
    logic          mods [3];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; sync = 1'b0; modify_sel = 1'b0;
        Re_in = '0; Im_in = '0;
        model_reset();
        mods[0] = 1'b1; mods[1] = 1'b0; mods[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Ramp frame, sync at index 0 (legal, no error)
        base = en_count;
        for (int k = 0; k < N; k++) begin
            neg_k = 16'(0 - k);
            step(1'b1, (k == 0), 1'b1, 16'(k), neg_k);
        end
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check_val("ramp_en_count", 32'(en_count - base), 32'd8);
        check_val("ramp_no_err", 32'(err_count), 32'd0);

        // Same ramp with bubbles between every sample
        base = en_count;
        for (int k = 0; k < N; k++) begin
            neg_k = 16'(0 - k);
            step(1'b1, 1'b0, 1'b0, 16'(k), neg_k);
            step(1'b0, 1'b0, 1'b1, 16'hDEAD, 16'hBEEF);
        end
        check_val("bubble_en_count", 32'(en_count - base), 32'd8);

        // Three back-to-back frames, modify_sel 1,0,1 at each index 0
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) begin
                step(1'b1, 1'b0, (k == 0) ? mods[f] : ~mods[f],
                     16'($urandom), 16'($urandom));
            end
        end

        // Resync on sample 5, then a complete new frame
        base = err_count;
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
        step(1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222);
        for (int k = 1; k < N; k++) step(1'b1, 1'b0, 1'b0, 16'(k * 3), 16'(k * 5));
        check_val("resync_err_pulses", 32'(err_count - base), 32'd1);

        // Extreme values alternating
        for (int k = 0; k < N; k++) begin
            step(1'b1, 1'b0, 1'b0, (k % 2 == 0) ? 16'h7FFF : 16'h8000,
                 (k % 2 == 0) ? 16'h8000 : 16'h7FFF);
        end

        // Random stream with occasional bubbles and resyncs
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
                 1'($urandom), 16'($urandom), 16'($urandom));
        end

        // Asynchronous reset mid-frame
        for (int k = 0; k < 11; k++) step(1'b1, 1'b0, 1'b1, 16'($urandom), 16'($urandom));
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = en_count;
        for (int k = 0; k < N; k++) step(1'b1, 1'b0, 1'b1, 16'(k + 100), 16'(200 - k));
        check_val("post_reset_en_count", 32'(en_count - base), 32'd8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
